// File: rtl/sa_pkg.sv
// Shared definitions for the weight-stationary systolic array.
// Holds the default data width and row count used by proc_elem, the array
// top and the activation feeder, the feeder FSM state encoding, and the
// helper that locates one element inside a packed activation vector.
package sa_pkg;

    // Default datapath geometry shared across the array.
    localparam int unsigned SA_WIDTH      = 3;
    localparam int unsigned SA_ROWS       = 3;
    localparam int unsigned SA_FEED_DEPTH = 4;

    // Activation feeder control states.
    typedef enum logic [1:0] {
        FEED_IDLE   = 2'd0,
        FEED_STREAM = 2'd1,
        FEED_DRAIN  = 2'd2
    } feed_state_e;

    // LSB position of element idx in a packed vector of width-bit elements.
    function automatic int unsigned elem_lsb(input int unsigned idx,
                                             input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/sa_vec_fifo.sv
// Synchronous FIFO holding activation vectors plus their burst-last tag.
// Ports:
//   clk, reset     rising-edge clock, synchronous active-high reset
//   i_push         write i_push_data (ignored while full)
//   i_push_data    entry to store
//   i_pop          retire the head entry (ignored while empty)
//   o_pop_data     current head entry (valid while !o_empty)
//   o_full         DEPTH entries stored
//   o_empty        no entries stored
//   o_count        number of entries stored
module sa_vec_fifo #(
    parameter int unsigned DW    = 10,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [DW-1:0]            i_push_data,
    input  logic                     i_pop,
    output logic [DW-1:0]            o_pop_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    // Storage array; contents need no reset since the pointers gate reads.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_pop_data = r_mem[r_rd_ptr];
    assign o_full     = (r_count == CW'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;

endmodule

// File: rtl/sa_act_feeder.sv
// Activation feeder on the left edge of the systolic array.
// Buffers incoming activation vectors, pops one per cycle unless the array
// is loading weights, and drives each row through a diagonal skew so row i
// lags row 0 by i cycles. Signals the end of a burst with a done pulse.
// Ports:
//   clk, reset   rising-edge clock, synchronous active-high reset
//   in_valid     upstream vector valid
//   in_ready     feeder accepts a vector this cycle
//   in_vec       activation vector, element i at [i*WIDTH +: WIDTH]
//   in_last      tags the final vector of a burst
//   hold         array loading weights; suppress pops
//   out_val      per-row activation, row i at [i*WIDTH +: WIDTH]
//   out_valid    per-row valid
//   busy         a burst is in progress
//   done         one-cycle pulse as the last element leaves row ROWS-1
module sa_act_feeder
    import sa_pkg::*;
#(
    parameter int unsigned WIDTH = SA_WIDTH,
    parameter int unsigned ROWS  = SA_ROWS,
    parameter int unsigned DEPTH = SA_FEED_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ROWS*WIDTH-1:0] in_vec,
    input  logic                  in_last,
    input  logic                  hold,
    output logic [ROWS*WIDTH-1:0] out_val,
    output logic [ROWS-1:0]       out_valid,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned VW   = ROWS * WIDTH;
    localparam int unsigned EW   = VW + 1;
    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CNTW = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic [EW-1:0]   w_head;
    logic [VW-1:0]   w_head_vec;
    logic            w_head_last;
    logic            w_fifo_full;
    logic            w_fifo_empty;
    logic [AW:0]     w_fifo_count;
    logic            w_unused_count;
    logic            w_push;
    logic            w_pop;

    feed_state_e     r_state;
    logic [CNTW-1:0] r_drain_cnt;
    logic            r_done;
    logic            r_last_seen;

    // Ready comes from registered state only, so a pop while full reopens
    // it one cycle later; it also blocks new bursts until done has fired.
    assign in_ready = !reset && !w_fifo_full && !r_last_seen;
    assign w_push   = in_valid && in_ready;
    assign w_pop    = !w_fifo_empty && !hold;

    // Occupancy is already summarised by full/empty.
    assign w_unused_count = ^w_fifo_count;

    sa_vec_fifo #(
        .DW    (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_push_data ({in_last, in_vec}),
        .i_pop       (w_pop),
        .o_pop_data  (w_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_count     (w_fifo_count)
    );

    assign w_head_vec  = w_head[VW-1:0];
    assign w_head_last = w_head[VW];

    // Burst control: done lands on the cycle the last vector's final
    // element is visible on row ROWS-1, and busy clears the cycle after.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= FEED_IDLE;
            r_drain_cnt <= '0;
            r_done      <= 1'b0;
            r_last_seen <= 1'b0;
        end else begin
            r_done <= 1'b0;

            // Ready reopens the cycle after the done pulse.
            if (w_push && in_last) begin
                r_last_seen <= 1'b1;
            end else if (r_done) begin
                r_last_seen <= 1'b0;
            end

            case (r_state)
                FEED_IDLE: begin
                    if (w_push) begin
                        r_state <= FEED_STREAM;
                    end
                end
                FEED_STREAM: begin
                    if (w_pop && w_head_last) begin
                        r_state     <= FEED_DRAIN;
                        r_drain_cnt <= CNTW'(ROWS - 1);
                        r_done      <= (ROWS == 1);
                    end
                end
                FEED_DRAIN: begin
                    // Nothing is left to pop here, so hold has no effect.
                    if (r_drain_cnt == '0) begin
                        r_state <= FEED_IDLE;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - CNTW'(1);
                        r_done      <= (r_drain_cnt == CNTW'(1));
                    end
                end
                default: begin
                    r_state <= FEED_IDLE;
                end
            endcase
        end
    end

    assign busy = (r_state != FEED_IDLE);
    assign done = r_done;

    // Per-row delay lines of gi+1 stages; a missed pop injects a bubble.
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
        logic [WIDTH-1:0] r_dl_val [gi+1];
        logic             r_dl_vld [gi+1];

        always_ff @(posedge clk) begin
            if (reset) begin
                for (int s = 0; s <= gi; s++) begin
                    r_dl_val[s] <= '0;
                    r_dl_vld[s] <= 1'b0;
                end
            end else begin
                r_dl_val[0] <= w_pop ? w_head_vec[elem_lsb(gi, WIDTH) +: WIDTH] : '0;
                r_dl_vld[0] <= w_pop;
                for (int s = 1; s <= gi; s++) begin
                    r_dl_val[s] <= r_dl_val[s-1];
                    r_dl_vld[s] <= r_dl_vld[s-1];
                end
            end
        end

        assign out_val[elem_lsb(gi, WIDTH) +: WIDTH] = r_dl_val[gi];
        assign out_valid[gi]                         = r_dl_vld[gi];
    end

endmodule

// File: doc/sa_act_feeder.md
Name: sa_act_feeder

Overview:
- Upstream stage of the weight-stationary systolic array. Sits directly in front of the proc_elem grid, on the left edge.
- Accepts activation row-vectors through a valid/ready handshake and buffers them in a small FIFO.
- Pops one vector per cycle and drives the array's row inputs (in_val of each row-0-column PE), skewed diagonally: row i lags row 0 by i cycles.
- Emits bubbles (zero, invalid) while the array is loading weights, and signals when a burst has fully drained.

Parameters:
- WIDTH, 3, bits per activation element; matches the proc_elem data width.
- ROWS, 3, number of array rows, which is also the elements per vector.
- DEPTH, 4, FIFO depth in vectors (power of 2, ≥2).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream vector valid.
- in_ready  out  1  feeder can accept a vector this cycle.
- in_vec  in  ROWS*WIDTH  activation vector; element i at bits [i*WIDTH +: WIDTH].
- in_last  in  1  qualifies the final vector of a burst.
- hold  in  1  array is loading weights; suppress pops.
- out_val  out  ROWS*WIDTH  per-row activation to the array; row i at [i*WIDTH +: WIDTH].
- out_valid  out  ROWS  per-row valid.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse when the last element of the burst leaves row ROWS-1.

Behaviour:
- Reset values: in_ready=0 during reset, 1 on the first cycle after reset. out_val=0, out_valid=0, busy=0, done=0. FIFO is emptied, skew registers are zeroed, state goes to IDLE.
- Reset asserted mid-burst discards all buffered and in-flight data. No done is produced.
- Handshake: a vector transfers on an edge where in_valid && in_ready.
- in_ready = !fifo_full && !last_seen. last_seen sets when an in_last vector is accepted and clears when done fires.
- Pop condition: FIFO non-empty && !hold. At most one pop per cycle.
- When pop is false, row 0 gets a bubble: value 0, valid 0.
- Skew pipeline: row i output is a registered delay line of i+1 stages fed with element i of the popped vector plus a valid bit. The pipeline shifts every cycle, including under hold.
- Latency: a vector accepted at edge k into an empty FIFO with hold=0 appears on row 0 after edge k+1, and on row i after edge k+1+i.
- Simultaneous push and pop: allowed whenever FIFO is non-full. The count is unchanged.
- Full: in_ready=0. A pop in the same cycle does not reopen in_ready until the next cycle (in_ready is registered-count based).
- Empty with hold=0: bubble issued; state is unaffected.
- FIFO pointers: log2(DEPTH) bits, wrap naturally. The count is log2(DEPTH)+1 bits.
- FSM:
  - IDLE -> STREAM on the first accepted vector.
  - STREAM -> DRAIN on the pop of the vector tagged last. A drain counter loads ROWS-1.
  - DRAIN decrements the counter each cycle. In DRAIN, hold is ignored, since nothing remains to pop.
  - At counter 0 the FSM asserts done for one cycle, coinciding with out_valid[ROWS-1] of the last vector, and returns to IDLE.
  - For ROWS=1, done coincides with the pop cycle's output.
- The in_last tag is stored alongside each vector in the FIFO.
- No arithmetic on data; values pass through bit-exact.

Decomposition:
- Package sa_pkg holds:
  - default WIDTH and ROWS constants shared with proc_elem and the array top;
  - the feeder FSM state encoding (IDLE, STREAM, DRAIN);
  - the vector element slice helper constants.
- One sub-module: sa_vec_fifo. It is a synchronous FIFO, WIDTH*ROWS+1 bits wide, DEPTH deep, with full/empty/count outputs. The skew delay lines stay inline in sa_act_feeder.

Test Plan (WIDTH=3, ROWS=3, DEPTH=4):
- Single vector {3,2,1} with in_last, hold=0, accepted at edge k:
  - row0 shows 1 valid after k+1;
  - row1 shows 2 after k+2;
  - row2 shows 3 after k+3;
  - done pulses with row2 valid;
  - busy drops the next cycle.
- Burst of 6 vectors, in_valid held high, hold=1 throughout:
  - in_ready drops after 4 acceptances;
  - all out_valid stay 0.
  - After hold released, vectors emerge on consecutive cycles in order, and in_ready reasserts one cycle after the first pop.
- hold toggled for 2 cycles mid-burst:
  - exactly 2 bubbles (value 0, valid 0) propagate diagonally;
  - no data is lost or duplicated.
- After in_last is accepted, in_valid stays high with vector {7,7,7}:
  - in_ready remains 0 until done;
  - {7,7,7} is accepted in the cycle after done.
- Reset asserted 2 cycles into a 3-vector burst:
  - next cycle all out_valid=0, out_val=0, busy=0, in_ready=1;
  - no done pulse.
- Empty FIFO with hold=0 for 5 cycles after reset: all outputs stay 0 and the state stays IDLE.
